asynchronous_fifo_read_controller: RTL and testbench
====================================================

Name: asynchronous_fifo_read_controller

Overview:
Read-domain controller of the dual-clock FIFO and the counterpart of the write controller.
- Synchronises the write-domain Gray write pointer into the read clock and derives `empty`.
- Issues synchronous-read requests to the shared dual-port RAM and returns registered read data with a valid strobe.
- Publishes its own Gray read pointer back to the write domain.

Parameters:
- DATA_WIDTH, 16: width of each stored word.
- DATA_DEPTH, 4096: RAM entries. Must be a power of 2 and at least 4. Usable capacity is DATA_DEPTH-1, because one slot is sacrificed to separate full from empty.
- ADDRESS_WIDTH, $clog2(DATA_DEPTH): pointer and address width (derived, not overridden).

Ports:
- clock, input, 1: read-domain clock.
- reset_n, input, 1: synchronous, active-low reset, sampled on clock.
- read_enable, input, 1: consumer read request.
- write_pointer_gray, input, ADDRESS_WIDTH: write pointer in Gray code, from the write clock domain (asynchronous).
- memory_read_data, input, DATA_WIDTH: RAM read port data, valid 1 cycle after the address is sampled.
- memory_read_enable, output, 1: RAM read strobe (combinational).
- memory_read_address, output, ADDRESS_WIDTH: RAM read address (combinational, equals read_pointer).
- read_data, output, DATA_WIDTH: registered data returned to the consumer.
- read_data_valid, output, 1: single-cycle strobe qualifying read_data.
- read_pointer_gray, output, ADDRESS_WIDTH: registered Gray read pointer, sent to the write domain.
- empty, output, 1: registered empty flag.

Behaviour:
- Reset values (reset_n low at a clock edge):
  - read_pointer = 0, both synchroniser stages = 0, read_pointer_gray = 0.
  - empty = 1, read_data = 0, read_data_valid = 0, internal return-pending flag = 0.
- Synchroniser:
  - write_pointer_gray passes through 2 flops (sync1 → sync2). No other logic touches sync1.
  - write_pointer_sync = gray_to_binary(sync2), combinational.
- Accept rule: accept = read_enable && !empty, using the registered empty.
  - memory_read_enable = accept.
  - memory_read_address = read_pointer.
- Pointer update on accept:
  - read_pointer advances by 1.
  - At read_pointer == DATA_DEPTH-1 it wraps to 0. No extra wrap bit.
- Next-state values:
  - _read_pointer = advanced or held read_pointer.
  - read_pointer_gray <= _read_pointer ^ (_read_pointer >> 1), so the Gray pointer is registered and glitch-free for the crossing.
  - empty <= (_read_pointer == write_pointer_sync).
- Read latency:
  - Accept at edge N; the RAM presents data during cycle N+1.
  - The controller registers it: read_data and read_data_valid = 1 after edge N+2.
  - read_data_valid is high for exactly 1 cycle per accept. read_data holds its value when valid is low.
- Throughput: 1 accept per cycle while not empty. Back-to-back accepts give back-to-back valid strobes, 2 cycles later, in order.
- Last entry: the accept that makes _read_pointer equal write_pointer_sync sets empty at the same edge. A read_enable on the following cycle is ignored.
- read_enable while empty: ignored. No pointer change, no memory_read_enable, no valid.
- Write visibility: a write_pointer_gray change sampled at edge M reaches sync2 at M+1. empty deasserts at edge M+2 at the earliest. This is pessimistic and safe.
- Full wrap: pointer sequence 0 → DATA_DEPTH-1 → 0 is transparent. Empty comparison and Gray encoding stay correct across the wrap.
- Reset mid-operation:
  - All state clears on the reset edge.
  - An in-flight read does not produce read_data_valid after reset deasserts.
  - The read and write domains must be reset together; any other reset sequencing is a system-level error.
- Assertions:
  - read_data_valid never rises without a matching accept 2 cycles earlier.
  - read_pointer never passes write_pointer_sync.
  - sync2 changes by at most 1 Gray bit per cycle.

Decomposition:
- Package asynchronous_fifo_package holds:
  - functions binary_to_gray and gray_to_binary, parameterised by width, shared with the write controller;
  - a localparam for synchroniser depth = 2.
- Sub-module gray_pointer_synchronizer: 2-stage flop chain with parameterised width and synchronous active-low reset. It is reused by the write controller for the read pointer.

Test Plan:
- Reset check: hold reset_n low 3 cycles with write_pointer_gray=0 → empty=1, read_pointer_gray=0, read_data_valid=0. read_enable high produces no memory_read_enable.
- Single write becoming visible: drive write_pointer_gray 0→1 at edge M → empty falls after M+2. Pulse read_enable → memory_read_address=0; read_data equals the RAM model word 2 cycles later; empty=1 again; read_pointer_gray=1.
- Burst read: DATA_DEPTH=8, write_pointer_gray=gray(7)=4'b0100 → 7 consecutive reads. Expect addresses 0..6, 7 valid strobes in order, empty at the last accept edge, and an 8th read_enable ignored.
- Wrap: drive the write pointer around the ring (gray 7, then 0, then 3). Expect reads at addresses 7, 0, 1, 2, then empty. read_pointer_gray sequence is 4, 0, 1, 3, 2.
- Mid-burst reset: assert reset_n low in the cycle after an accept → no read_data_valid afterwards, all outputs at reset values.
- Empty-read guard: hold read_enable high continuously while empty=1 for 10 cycles → no pointer movement, no valid strobes.

Source files
------------

// File: rtl/asynchronous_fifo_read_controller_pkg.sv
// Shared definitions for the dual-clock FIFO read and write controllers.
// Gray helpers work on a 32-bit container; callers cast to their pointer width.
package asynchronous_fifo_package;

  localparam int unsigned SyncStages = 2;

  function automatic logic [31:0] binary_to_gray(input logic [31:0] binary);
    return binary ^ (binary >> 1);
  endfunction

  function automatic logic [31:0] gray_to_binary(input logic [31:0] gray);
    logic [31:0] binary;
    binary[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      binary[i] = binary[i+1] ^ gray[i];
    end
    return binary;
  endfunction

endpackage

// File: rtl/asynchronous_fifo_read_controller_synchronizer.sv
// Multi-flop synchroniser for a Gray-coded pointer entering this clock domain.
// Stage 0 is the metastability-capturing flop; nothing else may read it.
module gray_pointer_synchronizer
  import asynchronous_fifo_package::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = SyncStages
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gray_pointer_i,
  output logic [WIDTH-1:0] gray_pointer_sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_d, stage_q;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], gray_pointer_i};
    if (!reset_n) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    stage_q <= stage_d;
  end

  assign gray_pointer_sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/asynchronous_fifo_read_controller.sv
// Read-domain controller of the dual-clock FIFO: empty detection, RAM read issue,
// registered data return and Gray read-pointer publication. DATA_DEPTH must be 2^n, n >= 2.
module asynchronous_fifo_read_controller
  import asynchronous_fifo_package::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DATA_DEPTH    = 4096,
  localparam int unsigned ADDRESS_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_pointer_gray,
  input  logic [DATA_WIDTH-1:0]    memory_read_data,
  output logic                     memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_read_address,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_data_valid,
  output logic [ADDRESS_WIDTH-1:0] read_pointer_gray,
  output logic                     empty
);

  localparam logic [ADDRESS_WIDTH-1:0] LastAddress = ADDRESS_WIDTH'(DATA_DEPTH - 1);

  logic [ADDRESS_WIDTH-1:0] write_pointer_sync2, write_pointer_sync;
  logic [ADDRESS_WIDTH-1:0] read_pointer_d, read_pointer_q;
  logic [ADDRESS_WIDTH-1:0] read_pointer_gray_d, read_pointer_gray_q;
  logic [DATA_WIDTH-1:0]    read_data_d, read_data_q;
  logic                     empty_d, empty_q;
  logic                     pending_d, pending_q;
  logic                     read_data_valid_d, read_data_valid_q;
  logic                     accept;

  gray_pointer_synchronizer #(
    .WIDTH  (ADDRESS_WIDTH),
    .STAGES (SyncStages)
  ) u_write_pointer_sync (
    .clock               (clock),
    .reset_n             (reset_n),
    .gray_pointer_i      (write_pointer_gray),
    .gray_pointer_sync_o (write_pointer_sync2)
  );

  assign write_pointer_sync = ADDRESS_WIDTH'(gray_to_binary(32'(write_pointer_sync2)));

  always_comb begin
    accept         = read_enable && !empty_q;
    read_pointer_d = read_pointer_q;
    if (accept) begin
      read_pointer_d = (read_pointer_q == LastAddress) ? '0 : read_pointer_q + 1'b1;
    end
    read_pointer_gray_d = ADDRESS_WIDTH'(binary_to_gray(32'(read_pointer_d)));
    // Compare against the already-synchronised write pointer: late but never optimistic.
    empty_d           = (read_pointer_d == write_pointer_sync);
    pending_d         = accept;
    read_data_valid_d = pending_q;
    read_data_d       = pending_q ? memory_read_data : read_data_q;
    if (!reset_n) begin
      read_pointer_d      = '0;
      read_pointer_gray_d = '0;
      empty_d             = 1'b1;
      pending_d           = 1'b0;
      read_data_valid_d   = 1'b0;
      read_data_d         = '0;
    end
  end

  always_ff @(posedge clock) begin
    read_pointer_q      <= read_pointer_d;
    read_pointer_gray_q <= read_pointer_gray_d;
    empty_q             <= empty_d;
    pending_q           <= pending_d;
    read_data_valid_q   <= read_data_valid_d;
    read_data_q         <= read_data_d;
  end

  assign memory_read_enable  = accept;
  assign memory_read_address = read_pointer_q;
  assign read_data           = read_data_q;
  assign read_data_valid     = read_data_valid_q;
  assign read_pointer_gray   = read_pointer_gray_q;
  assign empty               = empty_q;

  a_valid_has_accept : assert property (@(posedge clock) disable iff (!reset_n)
    read_data_valid_q |-> $past(accept, 2));

  a_no_overrun : assert property (@(posedge clock) disable iff (!reset_n)
    accept |-> (read_pointer_q != write_pointer_sync));

  a_sync_one_bit : assert property (@(posedge clock) disable iff (!reset_n)
    $past(reset_n) |-> ($countones(write_pointer_sync2 ^ $past(write_pointer_sync2)) <= 1));

endmodule

// File: tb/tb_asynchronous_fifo_read_controller.sv
// Bench for the FIFO read controller: directed vector table, reset/guard sequences,
// then random traffic against an occupancy-count model with a data scoreboard.
module tb_asynchronous_fifo_read_controller;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          read_enable = 1'b0;
  logic [AW-1:0] write_pointer_gray = '0;
  logic [DW-1:0] memory_read_data;
  logic          memory_read_enable;
  logic [AW-1:0] memory_read_address;
  logic [DW-1:0] read_data;
  logic          read_data_valid;
  logic [AW-1:0] read_pointer_gray;
  logic          empty;

  asynchronous_fifo_read_controller #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .read_enable         (read_enable),
    .write_pointer_gray  (write_pointer_gray),
    .memory_read_data    (memory_read_data),
    .memory_read_enable  (memory_read_enable),
    .memory_read_address (memory_read_address),
    .read_data           (read_data),
    .read_data_valid     (read_data_valid),
    .read_pointer_gray   (read_pointer_gray),
    .empty               (empty)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM model.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clock) if (memory_read_enable) ram_q <= mem[memory_read_address];
  assign memory_read_data = ram_q;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic re, input logic [AW-1:0] wpg, input logic rst_n);
    @(negedge clock);
    reset_n            = rst_n;
    read_enable        = re;
    write_pointer_gray = wpg;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Row: inputs for one cycle, combinational outputs in that cycle,
  // registered outputs after its closing edge. didx < 0 means read_data = 0.
  typedef struct {
    int re; int wpg; int mre; int addr; int valid; int didx; int empty; int rpg;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input int re, input int wpg, input int mre, input int addr,
                              input int valid, input int didx, input int empty, input int rpg);
    vec_t v;
    v.re = re; v.wpg = wpg; v.mre = mre; v.addr = addr;
    v.valid = valid; v.didx = didx; v.empty = empty; v.rpg = rpg;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_data;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

    // Burst of 7 then wrap: write pointer gray(7)=4, then gray(0)=0, then gray(3)=2.
    vecs.push_back(mk(0, 4, 0, 0, 0, -1, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 0, -1, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 0, -1, 0, 0));
    vecs.push_back(mk(1, 4, 1, 0, 0, -1, 0, 1));
    vecs.push_back(mk(1, 4, 1, 1, 1,  0, 0, 3));
    vecs.push_back(mk(1, 4, 1, 2, 1,  1, 0, 2));
    vecs.push_back(mk(1, 4, 1, 3, 1,  2, 0, 6));
    vecs.push_back(mk(1, 4, 1, 4, 1,  3, 0, 7));
    vecs.push_back(mk(1, 4, 1, 5, 1,  4, 0, 5));
    vecs.push_back(mk(1, 4, 1, 6, 1,  5, 1, 4));
    vecs.push_back(mk(1, 4, 0, 7, 1,  6, 1, 4));
    vecs.push_back(mk(0, 0, 0, 7, 0,  6, 1, 4));
    vecs.push_back(mk(0, 2, 0, 7, 0,  6, 1, 4));
    vecs.push_back(mk(0, 2, 0, 7, 0,  6, 0, 4));
    vecs.push_back(mk(1, 2, 1, 7, 0,  6, 0, 0));
    vecs.push_back(mk(1, 2, 1, 0, 1,  7, 0, 1));
    vecs.push_back(mk(1, 2, 1, 1, 1,  0, 0, 3));
    vecs.push_back(mk(1, 2, 1, 2, 1,  1, 1, 2));
    vecs.push_back(mk(1, 2, 0, 3, 1,  2, 1, 2));
    vecs.push_back(mk(0, 2, 0, 3, 0,  2, 1, 2));

    // Reset: 3 cycles low, read_enable high after the first edge.
    drive(0, 0, 0);
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0);
      chk("reset_mre", 32'(memory_read_enable), 0);
      tick;
    end
    chk("reset_empty", 32'(empty), 1);
    chk("reset_rpg", 32'(read_pointer_gray), 0);
    chk("reset_valid", 32'(read_data_valid), 0);
    chk("reset_data", 32'(read_data), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].re[0], AW'(vecs[i].wpg), 1);
      chk($sformatf("v%0d_mre", i), 32'(memory_read_enable), 32'(vecs[i].mre));
      chk($sformatf("v%0d_addr", i), 32'(memory_read_address), 32'(vecs[i].addr));
      tick;
      exp_data = (vecs[i].didx < 0) ? '0 : mem[vecs[i].didx];
      chk($sformatf("v%0d_valid", i), 32'(read_data_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_data", i), 32'(read_data), 32'(exp_data));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
      chk($sformatf("v%0d_rpg", i), 32'(read_pointer_gray), 32'(vecs[i].rpg));
    end

    // Empty guard: read_enable held while empty.
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'b010, 1);
      chk("guard_mre", 32'(memory_read_enable), 0);
      chk("guard_addr", 32'(memory_read_address), 3);
      tick;
      chk("guard_valid", 32'(read_data_valid), 0);
      chk("guard_rpg", 32'(read_pointer_gray), 2);
      chk("guard_empty", 32'(empty), 1);
    end

    // Mid-burst reset: one more word visible, accept it, then reset the next cycle.
    for (int i = 0; i < 3; i++) begin
      drive(0, 3'b110, 1);
      tick;
    end
    chk("mid_visible", 32'(empty), 0);
    drive(1, 3'b110, 1);
    chk("mid_mre", 32'(memory_read_enable), 1);
    chk("mid_addr", 32'(memory_read_address), 3);
    tick;
    drive(0, 0, 0);
    tick;
    chk("mid_rst_valid", 32'(read_data_valid), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_rpg", 32'(read_pointer_gray), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1);
      chk("post_rst_addr", 32'(memory_read_address), 0);
      tick;
      chk("post_rst_valid", 32'(read_data_valid), 0);
      chk("post_rst_data", 32'(read_data), 0);
      chk("post_rst_empty", 32'(empty), 1);
    end

    // Random traffic: model tracks total words written and read as plain counts.
    begin
      int w = 0, r = 0, s1 = 0, s2 = 0, s2_pre;
      bit empty_m = 1, acc, acc_d1 = 0, re;
      logic [DW-1:0] sb[$];
      logic [DW-1:0] dpipe = '0, dexp = '0, dnext;
      for (int c = 0; c < 500; c++) begin
        @(negedge clock);
        re = ($urandom_range(0, 9) < 6);
        if ((w - r) < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
          mem[w % DEPTH] = DW'($urandom);
          sb.push_back(mem[w % DEPTH]);
          w++;
        end
        read_enable        = re;
        write_pointer_gray = AW'(gray(w % DEPTH));
        #1;
        acc   = re && !empty_m;
        dnext = dpipe;
        chk("rnd_mre", 32'(memory_read_enable), 32'(acc));
        chk("rnd_addr", 32'(memory_read_address), 32'(r % DEPTH));
        if (acc) begin
          dnext = sb.pop_front();
          r++;
        end
        tick;
        if (acc_d1) dexp = dpipe;
        chk("rnd_valid", 32'(read_data_valid), 32'(acc_d1));
        chk("rnd_data", 32'(read_data), 32'(dexp));
        acc_d1  = acc;
        dpipe   = dnext;
        s2_pre  = s2;
        s2      = s1;
        s1      = w;
        empty_m = (r == s2_pre);
        chk("rnd_empty", 32'(empty), 32'(empty_m));
        chk("rnd_rpg", 32'(read_pointer_gray), 32'(gray(r % DEPTH)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
